// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle for the packet write arbiter.
// The requester side drives beats and wfull; the arbiter side returns grants and FIFO writes.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic                  tout_err;

    modport master (
        output req, req_last, req_data, wfull,
        input  gnt, winc, wdata, owner, busy, tout_err
    );

    modport slave (
        input  req, req_last, req_data, wfull,
        output gnt, winc, wdata, owner, busy, tout_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding one FIFO write port: an owner keeps the port for a whole
// packet, with a watchdog that forcibly releases an owner that stalls mid-packet.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int TOUT  = 16
) (
    input  logic          wclk,
    input  logic          wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(TOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_r;
    logic [OW-1:0]   rr_ptr_r;
    logic [OW-1:0]   owner_r;
    logic [CW-1:0]   idle_cnt_r;
    logic            busy_r;
    logic            tout_err_r;

    logic            own_req_s;
    logic            own_last_s;
    logic            beat_s;
    logic            idle_cyc_s;
    logic            tout_s;
    logic [OW-1:0]   nxt_ptr_s;
    logic [OW-1:0]   pick_s;
    logic            found_s;
    logic            hit_s;
    logic [OW:0]     sum_s;
    logic [OW-1:0]   idx_s;
    logic [DSIZE-1:0] wdata_s;

    // Owner-side qualifiers: accepted beat, counted idle cycle, watchdog expiry, next pointer.
    always_comb begin
        own_req_s  = bus.req[owner_r];
        own_last_s = bus.req_last[owner_r];
        beat_s     = (state_r == XFER) && own_req_s && !bus.wfull;
        idle_cyc_s = (state_r == XFER) && !own_req_s && !bus.wfull;
        tout_s     = idle_cyc_s && (idle_cnt_r == CW'(TOUT - 1));
        nxt_ptr_s  = (owner_r == OW'(NREQ - 1)) ? OW'(0) : owner_r + OW'(1);
    end

    // Rotating search: first requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_s  = rr_ptr_r;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = (OW+1)'(0);
        idx_s   = OW'(0);
        for (int k = 0; k < NREQ; k++) begin
            sum_s   = {1'b0, rr_ptr_r} + (OW+1)'(k);
            idx_s   = (sum_s >= (OW+1)'(NREQ)) ? OW'(sum_s - (OW+1)'(NREQ)) : OW'(sum_s);
            hit_s   = !found_s && bus.req[idx_s];
            pick_s  = hit_s ? idx_s : pick_s;
            found_s = found_s | hit_s;
        end
    end

    // Write-data mux from the current owner's lane.
    always_comb begin
        wdata_s = DSIZE'(0);
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == owner_r) begin
                wdata_s = bus.req_data[i*DSIZE +: DSIZE];
            end else begin
                wdata_s = wdata_s;
            end
        end
    end

    // Grant and write strobe are combinational so a beat moves in the same cycle it is offered.
    always_comb begin
        bus.gnt      = beat_s ? (NREQ'(1) << owner_r) : NREQ'(0);
        bus.winc     = beat_s;
        bus.wdata    = wdata_s;
        bus.owner    = owner_r;
        bus.busy     = busy_r;
        bus.tout_err = tout_err_r;
    end

    // Arbitration FSM with owner-idle watchdog.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= OW'(0);
            owner_r    <= OW'(0);
            idle_cnt_r <= CW'(0);
            busy_r     <= 1'b0;
            tout_err_r <= 1'b0;
        end else begin
            tout_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    idle_cnt_r <= CW'(0);
                    if (found_s) begin
                        owner_r <= pick_s;
                        busy_r  <= 1'b1;
                        state_r <= XFER;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                XFER: begin
                    if (beat_s && own_last_s) begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        rr_ptr_r   <= nxt_ptr_s;
                        idle_cnt_r <= CW'(0);
                    end else if (tout_s) begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        rr_ptr_r   <= nxt_ptr_s;
                        tout_err_r <= 1'b1;
                        idle_cnt_r <= CW'(0);
                    end else if (own_req_s) begin
                        idle_cnt_r <= CW'(0);
                    end else if (idle_cyc_s && (idle_cnt_r != CW'(TOUT - 1))) begin
                        idle_cnt_r <= idle_cnt_r + CW'(1);
                    end else begin
                        idle_cnt_r <= idle_cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named wclk and wrst.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter DSIZE, default 8: data width per beat.
REQ-004 Parameter TOUT, default 16: consecutive owner-idle cycles inside a packet before forced release (>=2).
REQ-005 Port wclk  in  1  write-domain clock.
REQ-006 Port wrst  in  1  async active-high reset.
REQ-007 Port req  in  NREQ  per-requester beat valid.
REQ-008 Port req_last  in  NREQ  per-requester last-beat-of-packet flag, qualified by req.
REQ-009 Port req_data  in  NREQ*DSIZE  per-requester beat data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-010 Port gnt  out  NREQ  per-requester beat accept (one-hot or zero), combinational.
REQ-011 Port wfull  in  1  FIFO full flag, write-domain registered.
REQ-012 Port winc  out  1  FIFO write enable.
REQ-013 Port wdata  out  DSIZE  FIFO write data.
REQ-014 Port owner  out  clog2(NREQ)  current packet owner index; valid while busy.
REQ-015 Port busy  out  1  high in XFER.
REQ-016 Port tout_err  out  1  one-cycle pulse on forced release.

Function
REQ-017 The FSM SHALL have two states: IDLE and XFER.
REQ-018 In IDLE with any req bit high, the block SHALL select the first requester at or after rr_ptr (modulo NREQ), register it into owner, and enter XFER on the next edge.
REQ-019 In IDLE, winc, gnt and busy SHALL be 0 and no beat SHALL be accepted.
REQ-020 In XFER, a beat SHALL transfer in every cycle with req[owner]=1 and wfull=0: winc=1, gnt[owner]=1, wdata=req_data[owner].
REQ-021 In XFER with wfull=1, winc and gnt SHALL be 0, and the beat SHALL be held by the requester (valid/ready semantics; data must stay stable).
REQ-022 Requests from non-owners SHALL be ignored in XFER; their gnt SHALL stay 0.
REQ-023 A transferred beat with req_last[owner]=1 SHALL end the packet: next state IDLE, rr_ptr <= owner+1 modulo NREQ.
REQ-024 Latency: a req rising in IDLE at edge t SHALL give its first possible winc in cycle t+1; at most one IDLE cycle SHALL separate back-to-back packets.
REQ-025 idle_cnt SHALL count consecutive XFER cycles with req[owner]=0, clear on any cycle with req[owner]=1, and saturate.
REQ-026 Cycles with wfull=1 SHALL NOT advance idle_cnt.
REQ-027 When idle_cnt reaches TOUT-1 in a counted cycle, the block SHALL pulse tout_err, return to IDLE, and set rr_ptr <= owner+1.
REQ-028 winc SHALL never assert while wfull=1.
REQ-029 winc SHALL never assert in more than one cycle per accepted beat.
REQ-030 A single-beat packet (req and req_last together, wfull=0) SHALL complete in one XFER cycle.
REQ-031 rr_ptr wrap: owner NREQ-1 finishing SHALL set rr_ptr to 0.

Reset
REQ-032 On wrst high, asynchronously: state=IDLE, rr_ptr=0, owner=0, idle_cnt=0, busy=0, tout_err=0.
REQ-033 On wrst high, winc and gnt SHALL read 0 while reset is held.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from requester 0.
REQ-035 No beat SHALL be accepted in the edge on which wrst deasserts.

Verification
REQ-036 Requesters 0 and 2 each hold 3-beat packets, wfull=0: exactly 3 winc for 0, then 1 idle cycle, then 3 winc for 2; gnt never overlaps.
REQ-037 All 4 requesters hold continuous 1-beat packets: owner sequence is 0,1,2,3,0, with rr_ptr wrapping.
REQ-038 wfull=1 for 5 cycles mid-packet: winc=0 and gnt=0 throughout; the packet resumes afterward with no lost or duplicated data.
REQ-039 With TOUT=4, the owner drops req for 4 cycles without last: tout_err pulses once, busy falls, and the next requester is granted.
REQ-040 wrst pulsed during beat 2 of owner 3: outputs clear immediately; after release, requester 0 wins over 3 when both request.
REQ-041 Scoreboard: the FIFO write stream equals the concatenation of granted packets in grant order for random req, last and wfull over 10k cycles.
